// File: rtl/mem_ctrl.sv
// Load/store controller: breaks byte, halfword and word accesses into sequential
// byte transfers on a byte-wide RAM whose read data arrives one cycle after ram_re.
module mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [2:0]  read_op,
    input  logic [1:0]  write_op,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] ram_addr,
    output logic        ram_re,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam logic [2:0] LB    = 3'b000;
    localparam logic [2:0] LH    = 3'b001;
    localparam logic [2:0] LW    = 3'b010;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;
    localparam logic [1:0] SB    = 2'b00;
    localparam logic [1:0] SH    = 2'b01;
    localparam logic [1:0] SW    = 2'b10;
    localparam logic [1:0] SNONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_size;
    logic        r_signed;
    logic [31:0] r_buf;
    logic [23:0] r_wshift;

    logic        w_rd_req;
    logic        w_wr_req;
    logic        w_req_signed;
    logic        w_misalign;
    logic [2:0]  w_req_size;
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_ext;

    // Unlisted load codes fall out of this set and therefore behave as LNONE.
    assign w_rd_req     = read_op inside {LB, LH, LW, LBU, LHU};
    assign w_wr_req     = (write_op != SNONE);
    assign w_req_signed = ~read_op[2];
    assign busy         = (r_state != ST_IDLE);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_req_size = 3'd1;
        if (w_rd_req) begin
            case (read_op[1:0])
                2'b01:   w_req_size = 3'd2;
                2'b10:   w_req_size = 3'd4;
                default: w_req_size = 3'd1;
            endcase
        end else begin
            case (write_op)
                SB:      w_req_size = 3'd1;
                SH:      w_req_size = 3'd2;
                SW:      w_req_size = 3'd4;
                default: w_req_size = 3'd1;
            endcase
        end
    end

    assign w_misalign = ((w_req_size == 3'd2) && addr[0]) ||
                        ((w_req_size == 3'd4) && (addr[1:0] != 2'b00));

    // The byte strobed in cycle k arrives in cycle k+1, so it lands in lane k-1 = r_cnt-2.
    always_comb begin
        w_rd_word = r_buf;
        case (r_cnt)
            3'd2:    w_rd_word[7:0]   = ram_rdata;
            3'd3:    w_rd_word[15:8]  = ram_rdata;
            3'd4:    w_rd_word[23:16] = ram_rdata;
            3'd5:    w_rd_word[31:24] = ram_rdata;
            default: w_rd_word        = r_buf;
        endcase
    end

    always_comb begin
        case (r_size)
            3'd1:    w_rd_ext = {{24{r_signed & w_rd_word[7]}}, w_rd_word[7:0]};
            3'd2:    w_rd_ext = {{16{r_signed & w_rd_word[15]}}, w_rd_word[15:0]};
            default: w_rd_ext = w_rd_word;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_size     <= 3'd1;
            r_signed   <= 1'b0;
            r_buf      <= 32'h0;
            r_wshift   <= 24'h0;
            rdata      <= 32'h0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            ram_addr   <= 32'h0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            ram_wdata  <= 8'h0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req || w_wr_req) begin
                        r_size   <= w_req_size;
                        r_signed <= w_req_signed;
                        r_cnt    <= 3'd1;
                        if (w_misalign) begin
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (w_rd_req) begin
                            r_state  <= ST_READ;
                            r_buf    <= 32'h0;
                            ram_addr <= addr;
                            ram_re   <= 1'b1;
                        end else begin
                            r_state   <= ST_WRITE;
                            r_wshift  <= wdata[31:8];
                            ram_addr  <= addr;
                            ram_wdata <= wdata[7:0];
                            ram_we    <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_buf <= w_rd_word;
                    if (r_cnt < r_size) begin
                        ram_addr <= ram_addr + 32'd1;
                    end else begin
                        ram_re <= 1'b0;
                    end
                    if (r_cnt == r_size + 3'd1) begin
                        rdata   <= w_rd_ext;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < r_size) begin
                        ram_addr  <= ram_addr + 32'd1;
                        ram_wdata <= r_wshift[7:0];
                        r_wshift  <= {8'h00, r_wshift[23:8]};
                    end else begin
                        ram_we  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a byte-RAM model answers the DUT, and a
// transaction-level reference predicts every cycle's strobes, done and rdata.
module tb_mem_ctrl;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LNONE = 3'b111;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SNONE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [2:0]  read_op;
    logic [1:0]  write_op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_rdata;
    logic [31:0] last_addr;
    logic [7:0]  last_wd;

    mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .read_op    (read_op),
        .write_op   (write_op),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Byte RAM: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= ram_rd(ram_addr);
        else        ram_rdata <= 8'($urandom);
        if (ram_we) ram[ram_addr] = ram_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sample_check(input string tag, input logic re, input logic we,
                                input logic [31:0] a, input logic [7:0] wd, input logic b,
                                input logic dn, input logic mis, input logic [31:0] rd);
        check({tag, ".ram_re"},     64'(ram_re),     64'(re));
        check({tag, ".ram_we"},     64'(ram_we),     64'(we));
        check({tag, ".ram_addr"},   64'(ram_addr),   64'(a));
        check({tag, ".ram_wdata"},  64'(ram_wdata),  64'(wd));
        check({tag, ".busy"},       64'(busy),       64'(b));
        check({tag, ".done"},       64'(done),       64'(dn));
        check({tag, ".misaligned"}, 64'(misaligned), 64'(mis));
        check({tag, ".rdata"},      64'(rdata),      64'(rd));
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic idle_cycle(input string tag);
        read_op  = LNONE;
        write_op = SNONE;
        addr     = $urandom;
        wdata    = $urandom;
        @(negedge clk);
        sample_check(tag, 1'b0, 1'b0, last_addr, last_wd, 1'b0, 1'b0, 1'b0, exp_rdata);
    endtask

    // Drives one request at the current negedge and checks every cycle up to its done cycle.
    // Returns at the negedge of the done cycle, leaving the caller free to issue the next request.
    task automatic run_op(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          is_rd;
        bit          is_wr;
        bit          is_signed;
        int          n;
        int          d;
        longint      v;
        logic [31:0] new_rdata;
        logic [31:0] ca;
        is_rd     = rop inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        is_wr     = !is_rd && (wop != SNONE);
        read_op   = rop;
        write_op  = wop;
        addr      = a;
        wdata     = wd;
        if (!is_rd && !is_wr) begin
            @(negedge clk);
            sample_check({tag, ".none"}, 1'b0, 1'b0, last_addr, last_wd, 1'b0, 1'b0, 1'b0, exp_rdata);
            return;
        end
        if (is_rd) n = (rop[1:0] == 2'b10) ? 4 : (rop[1:0] == 2'b01) ? 2 : 1;
        else       n = (wop == SW) ? 4 : (wop == SH) ? 2 : 1;
        if ((a % n) != 0) begin
            @(negedge clk);
            sample_check({tag, ".mis"}, 1'b0, 1'b0, last_addr, last_wd, 1'b0, 1'b1, 1'b1, exp_rdata);
            return;
        end
        is_signed = is_rd && !rop[2] && (n < 4);
        v = 0;
        for (int j = 0; j < n; j++) v = v + (longint'(ref_rd(a + 32'(j))) << (8 * j));
        if (is_signed && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        new_rdata = v[31:0];
        d = is_rd ? n + 2 : n + 1;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            if (c <= n) begin
                ca        = a + 32'(c - 1);
                last_addr = ca;
                if (is_wr) begin
                    last_wd     = wd[8 * (c - 1) +: 8];
                    ref_mem[ca] = last_wd;
                end
            end
            if (c == d && is_rd) exp_rdata = new_rdata;
            sample_check($sformatf("%s.c%0d", tag, c), is_rd && c <= n, is_wr && c <= n,
                         last_addr, last_wd, c < d, c == d, 1'b0, exp_rdata);
            if (c < d) begin
                read_op  = 3'($urandom);
                write_op = 2'($urandom);
                addr     = $urandom;
                wdata    = $urandom;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 4)      return 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        else if (sel < 6) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else              return $urandom;
    endfunction

    initial begin
        reset    = 1'b1;
        read_op  = LNONE;
        write_op = SNONE;
        addr     = 32'h0;
        wdata    = 32'h0;
        exp_rdata = 32'h0;
        last_addr = 32'h0;
        last_wd   = 8'h0;
        poke(32'h100, 8'h78);
        poke(32'h101, 8'h56);
        poke(32'h102, 8'h34);
        poke(32'h103, 8'h12);
        poke(32'h201, 8'h80);

        repeat (2) @(negedge clk);
        sample_check("reset", 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        read_op = LW;
        addr    = 32'h100;
        @(negedge clk);
        sample_check("rst_prio", 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        idle_cycle("idle0");

        run_op("lw100", LW, SNONE, 32'h100, 32'h0);
        check("lw100.value", 64'(rdata), 64'h1234_5678);
        run_op("lb201", LB, SNONE, 32'h201, 32'h0);
        check("lb201.value", 64'(rdata), 64'hFFFF_FF80);
        run_op("lbu201", LBU, SNONE, 32'h201, 32'h0);
        check("lbu201.value", 64'(rdata), 64'h0000_0080);
        idle_cycle("idle1");
        run_op("sh302", LNONE, SH, 32'h302, 32'hAABB_CCDD);
        idle_cycle("idle2");
        check("sh302.byte0", 64'(ram_rd(32'h302)), 64'hDD);
        check("sh302.byte1", 64'(ram_rd(32'h303)), 64'hCC);
        run_op("lw102", LW, SNONE, 32'h102, 32'h0);
        check("lw102.value", 64'(rdata), 64'h0000_0080);

        // Store cut short by reset in its second cycle.
        read_op  = LNONE;
        write_op = SW;
        addr     = 32'h120;
        wdata    = 32'h1122_3344;
        @(negedge clk);
        read_op  = LNONE;
        write_op = SNONE;
        ref_mem[32'h120] = 8'h44;
        sample_check("rst_sw.c1", 1'b0, 1'b1, 32'h120, 8'h44, 1'b1, 1'b0, 1'b0, exp_rdata);
        @(negedge clk);
        ref_mem[32'h121] = 8'h33;
        sample_check("rst_sw.c2", 1'b0, 1'b1, 32'h121, 8'h33, 1'b1, 1'b0, 1'b0, exp_rdata);
        reset = 1'b1;
        @(negedge clk);
        exp_rdata = 32'h0;
        last_addr = 32'h0;
        last_wd   = 8'h0;
        sample_check("rst_sw.c3", 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        idle_cycle("rst_sw.c4");
        idle_cycle("rst_sw.c5");
        run_op("rst_lb", LB, SNONE, 32'h201, 32'h0);
        check("rst_lb.value", 64'(rdata), 64'hFFFF_FF80);

        run_op("lw_sw", LW, SW, 32'h100, 32'hDEAD_BEEF);
        run_op("b2b_lh", LH, SNONE, 32'h100, 32'h0);
        check("b2b_lh.value", 64'(rdata), 64'h0000_5678);

        run_op("top_sb", LNONE, SB, 32'hFFFF_FFFF, 32'h0000_00C3);
        run_op("top_lb", LB, SNONE, 32'hFFFF_FFFF, 32'h0);
        check("top_lb.value", 64'(rdata), 64'hFFFF_FFC3);
        run_op("top_lh", LH, SNONE, 32'hFFFF_FFFF, 32'h0);
        run_op("top_sw", LNONE, SW, 32'hFFFF_FFFC, 32'h0102_0304);
        run_op("top_lw", LW, SNONE, 32'hFFFF_FFFC, 32'h0);
        check("top_lw.value", 64'(rdata), 64'h0102_0304);

        for (int i = 0; i < 400; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom), 2'($urandom), rand_addr(), $urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < $urandom_range(1, 2); k++) idle_cycle($sformatf("rnd%0d.idle", i));
            end
        end
        idle_cycle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
